// File: rtl/one_bit_processor_param.sv
// one_bit_processor_param: parametrised single-bit processor.
// The program is shifted in serially on in_reg[0] while en is high.
// It executes one instruction per clock once en falls.
// Optional build macro OBP_INPUT_SYNC_EN places a 2-flop synchroniser on
// in_reg. The synchroniser covers both program loading and operand reads.
module one_bit_processor_param #(
  parameter int IN_REGS   = 2,
  parameter int OUT_REGS  = 7,
  parameter int INT_REGS  = 8,
  parameter int INSTR_MEM = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [IN_REGS-1:0]           in_reg,
  output logic [OUT_REGS-1:0]          out_reg,
  output logic                         running,
  output logic [$clog2(INSTR_MEM)-1:0] pc
);

  localparam int SEL_N   = IN_REGS + OUT_REGS + INT_REGS + 2;
  localparam int SEL_W   = $clog2(SEL_N);
  localparam int PC_W    = $clog2(INSTR_MEM);
  localparam int DST_W   = (SEL_W > PC_W) ? SEL_W : PC_W;
  localparam int INSTR_W = 3 + 2 * SEL_W + DST_W;
  localparam int LEN_W   = PC_W + 1;
  localparam int BIT_W   = $clog2(INSTR_W);
  localparam int ALL_N   = 1 << SEL_W;
  localparam int OUT_LO  = 2 + IN_REGS;
  localparam int INT_LO  = OUT_LO + OUT_REGS;
  localparam int CMP_W   = (DST_W > LEN_W) ? DST_W : LEN_W;

  logic [IN_REGS-1:0]   in_s;
  logic                 en_q;
  logic [INSTR_W-2:0]   shift_q, shift_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d, bit_base;
  logic [PC_W-1:0]      load_ptr_q, ptr_d, ptr_base;
  logic [LEN_W-1:0]     prog_len_q, len_d, len_base;
  logic [PC_W-1:0]      pc_q, pc_d, pc_inc;
  logic                 run_q, run_d;
  logic [OUT_REGS-1:0]  out_q, out_d;
  logic [INT_REGS-1:0]  int_q, int_d;
  logic                 mem_we;
  logic [INSTR_W-1:0]   mem_q [INSTR_MEM];

  logic [ALL_N-1:0]     all_bits;
  logic [INSTR_W-1:0]   instr;
  logic [2:0]           op;
  logic [SEL_W-1:0]     src_a, src_b;
  logic [DST_W-1:0]     dst;
  logic                 a_bit, b_bit, res, wr, take;

`ifdef OBP_INPUT_SYNC_EN
  logic [IN_REGS-1:0] sync1_q, sync2_q;

  // Two-stage synchroniser for the asynchronous pad inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_reg;
      sync2_q <= sync1_q;
    end
  end
  assign in_s = sync2_q;
`else
  assign in_s = in_reg;
`endif

  assign out_reg = out_q;
  assign running = run_q;
  assign pc      = pc_q;

  // Flatten the select space into one bit vector: consts, inputs, outputs, internals
  always_comb begin
    all_bits                   = '0;
    all_bits[1]                = 1'b1;
    all_bits[OUT_LO-1:2]       = in_s;
    all_bits[INT_LO-1:OUT_LO]  = out_q;
    all_bits[SEL_N-1:INT_LO]   = int_q;
  end

  // Instruction decode and ALU for the word at the current pc
  always_comb begin
    instr = mem_q[pc_q];
    op    = instr[INSTR_W-1 -: 3];
    src_a = instr[INSTR_W-4 -: SEL_W];
    src_b = instr[DST_W +: SEL_W];
    dst   = instr[DST_W-1:0];
    a_bit = all_bits[src_a];
    b_bit = all_bits[src_b];
    res   = 1'b0;
    wr    = 1'b0;
    take  = 1'b0;
    case (op)
      3'b001:  begin res = a_bit & b_bit; wr = 1'b1; end
      3'b010:  begin res = a_bit | b_bit; wr = 1'b1; end
      3'b011:  begin res = a_bit ^ b_bit; wr = 1'b1; end
      3'b100:  begin res = ~a_bit;        wr = 1'b1; end
      3'b101:  begin res = a_bit;         wr = 1'b1; end
      3'b110:  take = ~a_bit;
      3'b111:  take = a_bit;
      default: ;
    endcase
  end

  // Next-state logic for loading, run start/stop and execution
  always_comb begin
    // The first load cycle after en rises restarts the load from scratch
    bit_base = (en && !en_q) ? '0 : bitcnt_q;
    ptr_base = (en && !en_q) ? '0 : load_ptr_q;
    len_base = (en && !en_q) ? '0 : prog_len_q;
    pc_inc   = ({1'b0, pc_q} == prog_len_q - LEN_W'(1)) ? '0 : pc_q + PC_W'(1);

    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    ptr_d    = load_ptr_q;
    len_d    = prog_len_q;
    pc_d     = pc_q;
    run_d    = run_q;
    out_d    = out_q;
    int_d    = int_q;
    mem_we   = 1'b0;

    if (en) begin
      run_d   = 1'b0;
      pc_d    = '0;
      shift_d = {shift_q[INSTR_W-3:0], in_s[0]};
      ptr_d   = ptr_base;
      len_d   = len_base;
      if (bit_base == BIT_W'(INSTR_W - 1)) begin
        mem_we   = 1'b1;
        bitcnt_d = '0;
        ptr_d    = (ptr_base == PC_W'(INSTR_MEM - 1)) ? '0 : ptr_base + PC_W'(1);
        len_d    = (len_base == LEN_W'(INSTR_MEM)) ? len_base : len_base + LEN_W'(1);
      end else begin
        bitcnt_d = bit_base + BIT_W'(1);
      end
    end else if (en_q) begin
      // en just fell: drop any partial word, start from address 0 next cycle
      bitcnt_d = '0;
      pc_d     = '0;
      run_d    = (prog_len_q != '0);
    end else if (run_q) begin
      if (take) begin
        pc_d = (CMP_W'(dst) < CMP_W'(prog_len_q)) ? dst[PC_W-1:0] : '0;
      end else begin
        pc_d = pc_inc;
      end
      for (int k = 0; k < OUT_REGS; k++) begin
        if (wr && dst == DST_W'(OUT_LO + k)) out_d[k] = res;
      end
      for (int k = 0; k < INT_REGS; k++) begin
        if (wr && dst == DST_W'(INT_LO + k)) int_d[k] = res;
      end
    end
  end

  // Control, program-counter and bit-register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q       <= 1'b0;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      load_ptr_q <= '0;
      prog_len_q <= '0;
      pc_q       <= '0;
      run_q      <= 1'b0;
      out_q      <= '0;
      int_q      <= '0;
    end else begin
      en_q       <= en;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      load_ptr_q <= ptr_d;
      prog_len_q <= len_d;
      pc_q       <= pc_d;
      run_q      <= run_d;
      out_q      <= out_d;
      int_q      <= int_d;
    end
  end

  // Instruction memory: a completed word is written at the load pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < INSTR_MEM; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[ptr_base] <= {shift_q, in_s[0]};
    end
  end

endmodule

// File: tb/tb_one_bit_processor_param.sv
// Directed testbench for one_bit_processor_param at default parameters.
module tb_one_bit_processor_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] in_reg;
  logic [6:0] out_reg;
  logic       running;
  logic [3:0] pc;

  int total = 0;
  int bad   = 0;

  one_bit_processor_param dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .in_reg  (in_reg),
    .out_reg (out_reg),
    .running (running),
    .pc      (pc)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] enc(input logic [2:0] op, input logic [4:0] a,
                                      input logic [4:0] b, input logic [4:0] d);
    return {op, a, b, d};
  endfunction

  task automatic load_word(input logic [17:0] w);
    for (int i = 17; i >= 0; i--) begin
      in_reg[0] = w[i];
      tick();
    end
  endtask

  task automatic pulse_reset;
    reset = 1'b0;
    en    = 1'b0;
    #1;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load;
    en = 1'b1;
    load_word(18'h3FFFF);
    load_word(18'h00000);
    total++; if (dut.mem_q[0] !== 18'h3FFFF) begin bad++; $display("FAIL load_mem0 got=%h want=%h", dut.mem_q[0], 18'h3FFFF); end
    total++; if (dut.mem_q[1] !== 18'h00000) begin bad++; $display("FAIL load_mem1 got=%h want=%h", dut.mem_q[1], 18'h0); end
    total++; if (dut.prog_len_q !== 5'd2) begin bad++; $display("FAIL load_len got=%0d want=2", dut.prog_len_q); end
    total++; if (dut.load_ptr_q !== 4'd2) begin bad++; $display("FAIL load_ptr got=%0d want=2", dut.load_ptr_q); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL load_running got=%b want=0", running); end
  endtask

  task automatic test_reset;
    // five bits of a third word, then async reset mid-load
    in_reg[0] = 1'b1;
    repeat (5) tick();
    total++; if (dut.bitcnt_q !== 5'd5) begin bad++; $display("FAIL rst_prebits got=%0d want=5", dut.bitcnt_q); end
    reset = 1'b0;
    #1;
    total++; if (out_reg !== 7'h00) begin bad++; $display("FAIL rst_out got=%h want=00", out_reg); end
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL rst_pc got=%0d want=0", pc); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_running got=%b want=0", running); end
    total++; if (dut.prog_len_q !== 5'd0) begin bad++; $display("FAIL rst_len got=%0d want=0", dut.prog_len_q); end
    total++; if (dut.bitcnt_q !== 5'd0) begin bad++; $display("FAIL rst_bitcnt got=%0d want=0", dut.bitcnt_q); end
    total++; if (dut.load_ptr_q !== 4'd0) begin bad++; $display("FAIL rst_ptr got=%0d want=0", dut.load_ptr_q); end
    en = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      total++; if (dut.mem_q[i] !== 18'h0) begin bad++; $display("FAIL rst_mem%0d got=%h want=0", i, dut.mem_q[i]); end
    end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b want=0", running); end
  endtask

  task automatic test_mov;
    in_reg = 2'b00;
    en = 1'b1;
    load_word(enc(3'b101, 5'd3, 5'd0, 5'd4));
    total++; if (dut.prog_len_q !== 5'd1) begin bad++; $display("FAIL mov_len got=%0d want=1", dut.prog_len_q); end
    en = 1'b0;
    tick();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL mov_running got=%b want=1", running); end
    in_reg[1] = 1'b1;
    tick();
    total++; if (out_reg[0] !== 1'b1) begin bad++; $display("FAIL mov_follow1 got=%b want=1", out_reg[0]); end
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL mov_pc got=%0d want=0", pc); end
    in_reg[1] = 1'b0;
    tick();
    total++; if (out_reg[0] !== 1'b0) begin bad++; $display("FAIL mov_follow0 got=%b want=0", out_reg[0]); end
    in_reg[1] = 1'b1;
    tick();
    total++; if (out_reg !== 7'b0000001) begin bad++; $display("FAIL mov_out got=%b want=0000001", out_reg); end
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL mov_pc2 got=%0d want=0", pc); end
  endtask

  task automatic test_branch_shift;
    logic [4:0] pat;
    pulse_reset();
    in_reg = 2'b00;
    en = 1'b1;
    load_word(enc(3'b111, 5'd3, 5'd0, 5'd0));   // BRNZ in1 -> 0
    load_word(enc(3'b101, 5'd9, 5'd0, 5'd10));  // out6 <- out5
    load_word(enc(3'b101, 5'd8, 5'd0, 5'd9));
    load_word(enc(3'b101, 5'd7, 5'd0, 5'd8));
    load_word(enc(3'b101, 5'd6, 5'd0, 5'd7));
    load_word(enc(3'b101, 5'd5, 5'd0, 5'd6));
    load_word(enc(3'b101, 5'd4, 5'd0, 5'd5));
    load_word(enc(3'b101, 5'd2, 5'd0, 5'd4));   // out0 <- in0
    total++; if (dut.prog_len_q !== 5'd8) begin bad++; $display("FAIL br_len got=%0d want=8", dut.prog_len_q); end
    total++; if (out_reg !== 7'b0) begin bad++; $display("FAIL br_outhold got=%b want=0", out_reg); end
    en = 1'b0;
    tick();
    pat = 5'b10111;
    for (int p = 4; p >= 0; p--) begin
      in_reg[0] = pat[p];
      repeat (8) tick();
    end
    total++; if (out_reg !== 7'b0010111) begin bad++; $display("FAIL br_fill got=%b want=0010111", out_reg); end
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL br_pcwrap got=%0d want=0", pc); end
    in_reg = 2'b11;
    repeat (12) tick();
    total++; if (out_reg !== 7'b0010111) begin bad++; $display("FAIL br_frozen got=%b want=0010111", out_reg); end
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL br_hold_pc got=%0d want=0", pc); end
    in_reg = 2'b01;
    tick();
    total++; if (pc !== 4'd1) begin bad++; $display("FAIL br_release_pc got=%0d want=1", pc); end
    repeat (7) tick();
    total++; if (out_reg !== 7'b0101111) begin bad++; $display("FAIL br_shift1 got=%b want=0101111", out_reg); end
    repeat (16) tick();
    total++; if (out_reg !== 7'b0111111) begin bad++; $display("FAIL br_shift3 got=%b want=0111111", out_reg); end
    repeat (8) tick();
    total++; if (out_reg !== 7'b1111111) begin bad++; $display("FAIL br_shift4 got=%b want=1111111", out_reg); end
  endtask

  task automatic test_wrap;
    pulse_reset();
    in_reg = 2'b00;
    en = 1'b1;
    for (int k = 0; k < 18; k++) load_word({3'b000, 15'(k + 1)});
    total++; if (dut.mem_q[0] !== 18'd17) begin bad++; $display("FAIL wrap_mem0 got=%0d want=17", dut.mem_q[0]); end
    total++; if (dut.mem_q[1] !== 18'd18) begin bad++; $display("FAIL wrap_mem1 got=%0d want=18", dut.mem_q[1]); end
    total++; if (dut.mem_q[2] !== 18'd3) begin bad++; $display("FAIL wrap_mem2 got=%0d want=3", dut.mem_q[2]); end
    total++; if (dut.mem_q[15] !== 18'd16) begin bad++; $display("FAIL wrap_mem15 got=%0d want=16", dut.mem_q[15]); end
    total++; if (dut.prog_len_q !== 5'd16) begin bad++; $display("FAIL wrap_len got=%0d want=16", dut.prog_len_q); end
    en = 1'b0;
    tick();
    for (int k = 1; k <= 18; k++) begin
      tick();
      total++; if (pc !== 4'(k % 16)) begin bad++; $display("FAIL wrap_pc step%0d got=%0d want=%0d", k, pc, k % 16); end
    end
  endtask

  task automatic test_en_reassert;
    in_reg = 2'b00;
    en = 1'b1;
    load_word(enc(3'b101, 5'd1, 5'd0, 5'd4));
    load_word(enc(3'b101, 5'd0, 5'd0, 5'd5));
    load_word(enc(3'b101, 5'd1, 5'd0, 5'd6));
    load_word(enc(3'b101, 5'd0, 5'd0, 5'd7));
    load_word(enc(3'b101, 5'd1, 5'd0, 5'd8));
    load_word(enc(3'b101, 5'd0, 5'd0, 5'd9));
    load_word(enc(3'b101, 5'd1, 5'd0, 5'd10));
    en = 1'b0;
    tick();
    repeat (7) tick();
    total++; if (out_reg !== 7'h55) begin bad++; $display("FAIL re_out55 got=%h want=55", out_reg); end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL re_running got=%b want=1", running); end
    repeat (3) tick();
    en = 1'b1;
    tick();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL re_stop got=%b want=0", running); end
    total++; if (out_reg !== 7'h55) begin bad++; $display("FAIL re_outhold got=%h want=55", out_reg); end
    total++; if (dut.prog_len_q !== 5'd0) begin bad++; $display("FAIL re_len got=%0d want=0", dut.prog_len_q); end
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL re_pc got=%0d want=0", pc); end
    repeat (3) tick();
    en = 1'b0;
    tick();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL re_idle got=%b want=0", running); end
    repeat (4) tick();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL re_idle2 got=%b want=0", running); end
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL re_idle_pc got=%0d want=0", pc); end
    total++; if (out_reg !== 7'h55) begin bad++; $display("FAIL re_idle_out got=%h want=55", out_reg); end
  endtask

  initial begin
    reset  = 1'b0;
    en     = 1'b0;
    in_reg = 2'b00;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    test_load();
    test_reset();
    test_mov();
    test_branch_shift();
    test_wrap();
    test_en_reassert();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/one_bit_processor_param.md
Name: one_bit_processor_param

Overview:
- Parametrised successor of the 1-bit processor.
- Configurable input, output and internal bit-register counts and instruction-memory depth; 3-bit opcode ISA with unified bit-select space, conditional branches, and PC wrap at actual loaded program length.
- Program is loaded serially through in_reg[0] while en is high. Execution starts when en falls.
- Sits at the project top, directly on I/O pads.

Parameters:
IN_REGS, 2, number of input bits
OUT_REGS, 7, number of output bits
INT_REGS, 8, number of internal scratch bits
INSTR_MEM, 16, instruction memory depth (words)
Derived localparams:
- SEL_W = clog2(IN_REGS+OUT_REGS+INT_REGS+2)
- PC_W = clog2(INSTR_MEM)
- DST_W = max(SEL_W, PC_W)
- INSTR_W = 3+2*SEL_W+DST_W (18 at defaults)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  1 = load mode, 0 = run mode
in_reg  input  IN_REGS  input bits; in_reg[0] is also the serial program-load data
out_reg  output  OUT_REGS  registered output bits
running  output  1  high while executing (en=0 and prog_len>0)
pc  output  PC_W  current program counter

Behaviour:
- Reset (reset=0, async) clears: out_reg, internal regs, every instruction word, pc, load shift register, bit counter, load_ptr, prog_len. running=0.
- Select map:
  - 0 = const 0; 1 = const 1
  - 2..2+IN_REGS-1 = inputs
  - next OUT_REGS = outputs
  - next INT_REGS = internal
  - Defaults: in 2-3, out 4-10, int 11-18. Selects 19-31 read 0.
  - Writes to const, input or unmapped selects are ignored.
- Instruction word, MSB first: [op 3][srcA SEL_W][srcB SEL_W][dst DST_W].
- Opcodes:
  - 000 NOP
  - 001 AND, 010 OR, 011 XOR: dst=A op B
  - 100 NOT: dst=~A
  - 101 MOV: dst=A
  - 110 BRZ: if A==0, pc=dst
  - 111 BRNZ: if A==1, pc=dst
- Load mode (en=1):
  - Each cycle, in_reg[0] shifts in, MSB first.
  - After INSTR_W bits, the word is written to mem[load_ptr]; load_ptr increments and bit counter returns to 0.
  - prog_len = min(words loaded, INSTR_MEM).
  - load_ptr wraps INSTR_MEM-1 -> 0; later words overwrite from address 0; prog_len saturates at INSTR_MEM.
  - pc held at 0. out_reg and internal regs hold their values.
- en rising edge (run -> load): execution stops; load_ptr, bit counter and prog_len are cleared. Memory is not cleared; it is overwritten by the new load.
- en falling edge:
  - A partially shifted word is discarded.
  - pc=0; execution begins the next cycle if prog_len>0.
  - If prog_len==0, the block idles with running=0.
- Run mode: one instruction per clock.
  - Operands are sampled at the executing edge; the result is visible the cycle after.
  - Non-branch and not-taken branch: pc = (pc==prog_len-1) ? 0 : pc+1.
  - Taken branch: pc = dst if dst<prog_len, else 0.
- The same destination is never written twice in one cycle (single-issue), so there are no write conflicts.
- Reset mid-load or mid-run: immediate return to reset state.

Optional Feature:
- Macro: OBP_INPUT_SYNC_EN
- Defined: in_reg passes through a 2-flop synchroniser before all use, loading included. Load data and operand reads lag the pins by 2 cycles.
- Undefined: in_reg is used directly with no added latency.

Test Plan:
- Reset: drive reset=0 mid-load (en=1, 5 bits shifted), release -> out_reg=0, pc=0, prog_len=0, all mem words 0, running=0.
- Load: en=1, shift 18 ones then 18 zeros -> mem[0]=18'h3FFFF, mem[1]=0, mem[0] not overwritten.
- Single MOV program:
  - Load MOV srcA=3 (in1), dst=4 (out0); drop en.
  - Toggle in_reg[1] -> out_reg[0] follows with 1-cycle lag.
  - pc stays 0 (prog_len=1 wrap).
- Branch hold and shift register:
  - Program: BRNZ in1 -> self; MOV out5->out6 ... out0<-in0.
  - Hold in1=1 -> out_reg frozen at 7'b0010111.
  - Release -> shifts reach 7'b1111111 with in0=1.
- Wrap/overflow: load INSTR_MEM+2 words -> words 0 and 1 hold the last two words, prog_len=16, pc cycles 0..15.
- en re-assert during run with out_reg=7'h55 -> execution stops, out_reg holds 7'h55, prog_len=0; dropping en with no complete word -> running=0.
